// File: rtl/countdown_pkg.sv
`default_nettype none
// ============================================================================
// Module      : countdown_pkg
// Description : Shared types and constants for the countdown timer.
//               State encoding, display limits and the preset clamp helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MSEC_MAX = 99;
  localparam int SEC_MAX  = 59;

  // Presets above the largest displayable second saturate rather than wrap.
  function automatic logic [5:0] clamp_sec(input logic [5:0] s);
    return (s > 6'(SEC_MAX)) ? 6'(SEC_MAX) : s;
  endfunction

endpackage : countdown_pkg
`default_nettype wire

// File: rtl/countdown_timer_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Clock divider producing a one-cycle tick every DIV enabled
//               cycles. The phase is held while disabled and synchronously
//               cleared by i_clr.
// Ports       : clk    - system clock
//               reset  - synchronous active-high reset
//               i_en   - count enable (divider advances only when high)
//               i_clr  - synchronous clear to phase 0 (wins over i_en)
//               o_tick - high for one cycle when phase is DIV-1 and enabled
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;

  assign last   = (cnt_q == CW'(DIV - 1));
  assign o_tick = i_en & last;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : tick_gen
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : SS.cc countdown timer at TICK_HZ resolution. Loads a preset
//               in whole seconds, counts down to 00.00 and holds a done flag.
// Ports       : clk          - system clock
//               reset        - synchronous active-high reset
//               i_run_stop   - pulse: start / pause / resume (acknowledge done)
//               i_clear      - pulse: abort and reload the preset
//               i_load       - pulse: latch i_preset_sec (IDLE only)
//               i_preset_sec - preset seconds, values above 59 clamp to 59
//               o_msec       - centiseconds 0..99
//               o_sec        - seconds 0..59
//               o_running    - high while in RUN
//               o_done       - high while in DONE
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_run_stop,
  input  logic       i_clear,
  input  logic       i_load,
  input  logic [5:0] i_preset_sec,
  output logic [6:0] o_msec,
  output logic [5:0] o_sec,
  output logic       o_running,
  output logic       o_done
);

  localparam int DIV = CLK_HZ / TICK_HZ;

  state_t     state_q, state_d;
  logic [5:0] preset_q, preset_d;
  logic [5:0] sec_q, sec_d;
  logic [6:0] msec_q, msec_d;
  logic       running_q, running_d;
  logic       done_q, done_d;

  logic       tick_en, tick_clr, tick;
  logic       count_zero, last_tick;

  // Divider runs only in RUN, keeps its phase in PAUSE, restarts from 0
  // whenever the timer is idle or finished.
  assign tick_en  = (state_q == RUN);
  assign tick_clr = (state_q == IDLE) || (state_q == DONE);

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .i_en   (tick_en),
    .i_clr  (tick_clr),
    .o_tick (tick)
  );

  assign count_zero = (sec_q == 6'd0) && (msec_q == 7'd0);
  assign last_tick  = tick && (sec_q == 6'd0) && (msec_q == 7'd1);

  always_comb begin
    state_d  = state_q;
    preset_d = preset_q;
    sec_d    = sec_q;
    msec_d   = msec_q;

    case (state_q)
      IDLE: begin
        if (i_clear) begin
          sec_d  = preset_q;
          msec_d = 7'd0;
        end else if (i_run_stop) begin
          // Starting from 00.00 would finish instantly; stay idle instead.
          if (!count_zero) state_d = RUN;
        end else if (i_load) begin
          preset_d = clamp_sec(i_preset_sec);
          sec_d    = clamp_sec(i_preset_sec);
          msec_d   = 7'd0;
        end
      end

      RUN: begin
        if (i_clear) begin
          // Clear discards any tick arriving on the same edge.
          state_d = IDLE;
          sec_d   = preset_q;
          msec_d  = 7'd0;
        end else begin
          if (tick) begin
            if (msec_q == 7'd0) begin
              msec_d = 7'(MSEC_MAX);
              sec_d  = sec_q - 6'd1;
            end else begin
              msec_d = msec_q - 7'd1;
            end
          end
          // Reaching 00.00 takes precedence over a simultaneous pause so the
          // timer never sits paused at zero.
          if (last_tick) begin
            state_d = DONE;
          end else if (i_run_stop) begin
            state_d = PAUSE;
          end
        end
      end

      PAUSE: begin
        if (i_clear) begin
          state_d = IDLE;
          sec_d   = preset_q;
          msec_d  = 7'd0;
        end else if (i_run_stop) begin
          state_d = RUN;
        end
      end

      DONE: begin
        if (i_clear || i_run_stop) begin
          state_d = IDLE;
          sec_d   = preset_q;
          msec_d  = 7'd0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      preset_q  <= 6'd0;
      sec_q     <= 6'd0;
      msec_q    <= 7'd0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      preset_q  <= preset_d;
      sec_q     <= sec_d;
      msec_q    <= msec_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign o_sec     = sec_q;
  assign o_msec    = msec_q;
  assign o_running = running_q;
  assign o_done    = done_q;

endmodule : countdown_timer
`default_nettype wire
